// File: rtl/pixel_ctrl_pkg.sv
// Shared types and constants for the pixel frame controller.
// Frame states, bank count, default phase lengths and counter widths.
package pixel_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ERASE,
      ST_EXPOSE,
      ST_CONVERT,
      ST_READ,
      ST_DRAIN
   } state_t;

   localparam int N_BANKS       = 4;
   localparam int C_ERASE_DEF   = 5;
   localparam int C_EXPOSE_DEF  = 255;
   localparam int C_CONVERT_DEF = 255;
   localparam int C_READ_DEF    = 5;
   localparam int ADC_W         = 8;
   localparam int CNT_W         = 16;

   // Terminal count value for a phase of n cycles.
   function automatic logic [CNT_W-1:0] last_of(input int n);
      return CNT_W'(n - 1);
   endfunction

endpackage

// File: rtl/pixel_phase_cnt.sv
// Loadable up-counter with terminal-count flag.
// Shared by every phase; its low bits double as the ADC ramp code.
module pixel_phase_cnt
   import pixel_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] last_i,
   output logic [ADC_W-1:0] code_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: restart at zero on load, otherwise increment.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (load_i) begin
         cnt_d = '0;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign code_o = cnt_q[ADC_W-1:0];
   assign tc_o   = (cnt_q == last_i);

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer: erase/expose/convert strobes, ADC ramp, and
// per-bank readout onto a valid/ready byte stream.
module pixel_frame_ctrl
   import pixel_ctrl_pkg::*;
#(
   parameter int C_ERASE   = C_ERASE_DEF,
   parameter int C_EXPOSE  = C_EXPOSE_DEF,
   parameter int C_CONVERT = C_CONVERT_DEF,
   parameter int C_READ    = C_READ_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               continuous,
   input  logic               abort,
   output logic               erase,
   output logic               expose,
   output logic               convert,
   output logic [N_BANKS-1:0] read,
   output logic [ADC_W-1:0]   adc_code,
   input  logic [7:0]         pix_bus,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic               frame_done
);

   if (C_CONVERT < 1 || C_CONVERT > 256) begin : g_bad_convert
      $error("pixel_frame_ctrl: C_CONVERT must be in 1..256");
   end

   localparam logic [CNT_W-1:0] L_ERASE  = last_of(C_ERASE);
   localparam logic [CNT_W-1:0] L_EXPOSE = last_of(C_EXPOSE);
   localparam logic [CNT_W-1:0] L_CONV   = last_of(C_CONVERT);
   localparam logic [CNT_W-1:0] L_READ   = last_of(C_READ);

   state_t           state_q, state_d;
   logic [1:0]       b_q, b_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_last;
   logic [ADC_W-1:0] cnt_code;
   logic             cnt_tc;

   pixel_phase_cnt u_cnt (
      .clk    (clk),
      .rst    (reset),
      .load_i (cnt_load),
      .last_i (cnt_last),
      .code_o (cnt_code),
      .tc_o   (cnt_tc)
   );

   // Next-state, bank, capture and counter control.
   always_comb begin
      state_d  = state_q;
      b_d      = b_q;
      data_d   = data_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_last = '0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_load = 1'b1;
            if (start) state_d = ST_ERASE;
         end
         ST_ERASE: begin
            cnt_last = L_ERASE;
            if (cnt_tc) begin
               cnt_load = 1'b1;
               state_d  = ST_EXPOSE;
            end
         end
         ST_EXPOSE: begin
            cnt_last = L_EXPOSE;
            if (cnt_tc) begin
               cnt_load = 1'b1;
               state_d  = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            cnt_last = L_CONV;
            if (cnt_tc) begin
               cnt_load = 1'b1;
               b_d      = 2'd0;
               state_d  = ST_READ;
            end
         end
         ST_READ: begin
            cnt_last = L_READ;
            if (cnt_tc) begin
               cnt_load = 1'b1;
               data_d   = pix_bus;
               valid_d  = 1'b1;
               state_d  = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            cnt_load = 1'b1;
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               if (b_q != 2'd3) begin
                  b_d     = b_q + 2'd1;
                  state_d = ST_READ;
               end else begin
                  b_d     = 2'd0;
                  done_d  = 1'b1;
                  state_d = continuous ? ST_ERASE : ST_IDLE;
               end
            end
         end
         default: begin
            cnt_load = 1'b1;
            state_d  = ST_IDLE;
         end
      endcase
      if (abort) begin
         state_d  = ST_IDLE;
         b_d      = 2'd0;
         valid_d  = 1'b0;
         done_d   = 1'b0;
         cnt_load = 1'b1;
      end
   end

   // State, bank index and output-stream registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         b_q     <= 2'd0;
         data_q  <= 8'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign erase      = (state_q == ST_ERASE);
   assign expose     = (state_q == ST_EXPOSE);
   assign convert    = (state_q == ST_CONVERT);
   assign read       = (state_q == ST_READ) ? (N_BANKS'(1) << b_q) : '0;
   assign adc_code   = (state_q == ST_CONVERT) ? cnt_code : '0;
   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign out_last   = valid_q && (b_q == 2'd3);
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Directed bench for pixel_frame_ctrl with short phase lengths.
// Expected timelines are hand-written per cycle of a frame.
module tb_pixel_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       continuous = 1'b0;
   logic       abort = 1'b0;
   logic       erase, expose, convert;
   logic [3:0] read;
   logic [7:0] adc_code;
   logic [7:0] pix_bus;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_last;
   logic       busy;
   logic       frame_done;

   int npass = 0;
   int ntot  = 0;

   pixel_frame_ctrl #(
      .C_ERASE   (2),
      .C_EXPOSE  (3),
      .C_CONVERT (4),
      .C_READ    (2)
   ) dut (
      .clk        (clk),
      .reset      (rst),
      .start      (start),
      .continuous (continuous),
      .abort      (abort),
      .erase      (erase),
      .expose     (expose),
      .convert    (convert),
      .read       (read),
      .adc_code   (adc_code),
      .pix_bus    (pix_bus),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Pixel array model: enabled bank b drives 0x10+b.
   always_comb begin
      pix_bus = 8'hA5;
      if (read[0]) pix_bus = 8'h10;
      if (read[1]) pix_bus = 8'h11;
      if (read[2]) pix_bus = 8'h12;
      if (read[3]) pix_bus = 8'h13;
   end

   logic [18:0] act;
   assign act = {erase, expose, convert, read, adc_code,
                 out_valid, out_last, busy, frame_done};

   // Hand-derived frame timeline, t = cycles after start sampled.
   function automatic logic [18:0] exp_base(input int t);
      logic e, x, c, v, l, bz, d;
      logic [3:0] r;
      logic [7:0] a;
      e = 0; x = 0; c = 0; v = 0; l = 0; d = 0;
      r = 4'b0000; a = 8'h00;
      bz = (t >= 1 && t <= 21);
      if (t >= 1 && t <= 2) e = 1;
      if (t >= 3 && t <= 5) x = 1;
      if (t >= 6 && t <= 9) begin c = 1; a = 8'(t - 6); end
      if (t == 10 || t == 11) r = 4'b0001;
      if (t == 13 || t == 14) r = 4'b0010;
      if (t == 16 || t == 17) r = 4'b0100;
      if (t == 19 || t == 20) r = 4'b1000;
      if (t == 12 || t == 15 || t == 18 || t == 21) v = 1;
      if (t == 21) l = 1;
      if (t == 22) d = 1;
      return {e, x, c, r, a, v, l, bz, d};
   endfunction

   function automatic logic [7:0] exp_data(input int t);
      case (t)
         12: return 8'h10;
         15: return 8'h11;
         18: return 8'h12;
         21: return 8'h13;
         default: return 8'h00;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      continuous = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      ntot++;
      if (act !== 19'd0 || out_data !== 8'h00) begin
         $display("FAIL reset_async got %h/%h want 0/0", act, out_data);
      end else npass++;
      @(negedge clk);
      rst = 1'b0;
      tick();
      ntot++;
      if (act !== 19'd0 || out_data !== 8'h00) begin
         $display("FAIL reset_idle got %h/%h want 0/0", act, out_data);
      end else npass++;
   endtask

   task automatic test_frame();
      logic [18:0] e;
      out_ready = 1'b1;
      start = 1'b1;
      ntot++;
      if (act !== exp_base(0)) begin
         $display("FAIL frame t=0 got %h want %h", act, exp_base(0));
      end else npass++;
      for (int t = 1; t <= 23; t++) begin
         tick();
         start = 1'b0;
         e = exp_base(t);
         ntot++;
         if (act !== e) begin
            $display("FAIL frame t=%0d got %h want %h", t, act, e);
         end else npass++;
         if (e[3]) begin
            ntot++;
            if (out_data !== exp_data(t)) begin
               $display("FAIL frame_data t=%0d got %h want %h",
                        t, out_data, exp_data(t));
            end else npass++;
         end
      end
   endtask

   task automatic test_backpressure();
      logic [18:0] e;
      int m;
      out_ready = 1'b1;
      start = 1'b1;
      for (int t = 1; t <= 28; t++) begin
         tick();
         start = 1'b0;
         out_ready = !(t >= 12 && t <= 16);
         m = (t <= 12) ? t : (t <= 17) ? 12 : t - 5;
         e = exp_base(m);
         ntot++;
         if (act !== e) begin
            $display("FAIL backpressure t=%0d got %h want %h", t, act, e);
         end else npass++;
         if (e[3]) begin
            ntot++;
            if (out_data !== exp_data(m)) begin
               $display("FAIL bp_data t=%0d got %h want %h",
                        t, out_data, exp_data(m));
            end else npass++;
         end
      end
   endtask

   task automatic test_continuous();
      logic [18:0] e;
      int m;
      out_ready = 1'b1;
      continuous = 1'b1;
      start = 1'b1;
      for (int t = 1; t <= 43; t++) begin
         tick();
         start = 1'b0;
         if (t == 23) continuous = 1'b0;
         m = (t <= 21) ? t : t - 21;
         e = exp_base(m);
         if (t == 22) e[0] = 1'b1;
         ntot++;
         if (act !== e) begin
            $display("FAIL continuous t=%0d got %h want %h", t, act, e);
         end else npass++;
         if (e[3]) begin
            ntot++;
            if (out_data !== exp_data(m)) begin
               $display("FAIL cont_data t=%0d got %h want %h",
                        t, out_data, exp_data(m));
            end else npass++;
         end
      end
   endtask

   task automatic test_abort();
      start = 1'b1;
      for (int t = 1; t <= 9; t++) begin
         tick();
         start = 1'b0;
         abort = 1'b0;
         ntot++;
         if (act !== ((t <= 7) ? exp_base(t) : 19'd0)) begin
            $display("FAIL abort_convert t=%0d got %h", t, act);
         end else npass++;
         if (t == 7) abort = 1'b1;
      end
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      ntot++;
      if (act !== 19'd0) begin
         $display("FAIL abort_over_start got %h want 0", act);
      end else npass++;
      start = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         start = 1'b0;
         out_ready = (t < 11);
      end
      ntot++;
      if (act !== exp_base(12)) begin
         $display("FAIL abort_pre_drain got %h want %h", act, exp_base(12));
      end else npass++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      out_ready = 1'b1;
      ntot++;
      if (act !== 19'd0) begin
         $display("FAIL abort_drain got %h want 0", act);
      end else npass++;
      tick();
      ntot++;
      if (act !== 19'd0) begin
         $display("FAIL abort_no_done got %h want 0", act);
      end else npass++;
      test_frame();
   endtask

   task automatic test_async_reset();
      start = 1'b1;
      out_ready = 1'b1;
      for (int t = 1; t <= 13; t++) begin
         tick();
         start = 1'b0;
      end
      ntot++;
      if (act !== exp_base(13) || out_data !== 8'h10) begin
         $display("FAIL pre_reset got %h/%h want %h/10",
                  act, out_data, exp_base(13));
      end else npass++;
      #2;
      rst = 1'b1;
      #1;
      ntot++;
      if (act !== 19'd0 || out_data !== 8'h00) begin
         $display("FAIL reset_midread got %h/%h want 0/0", act, out_data);
      end else npass++;
      @(negedge clk);
      rst = 1'b0;
      tick();
      test_frame();
   endtask

   task automatic test_start_held();
      logic [18:0] e;
      int m;
      out_ready = 1'b1;
      continuous = 1'b0;
      start = 1'b1;
      for (int t = 1; t <= 26; t++) begin
         tick();
         m = (t <= 22) ? t : t - 22;
         e = exp_base(m);
         ntot++;
         if (act !== e) begin
            $display("FAIL start_held t=%0d got %h want %h", t, act, e);
         end else npass++;
      end
      start = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_frame();
      go_idle();
      test_backpressure();
      go_idle();
      test_continuous();
      go_idle();
      test_abort();
      go_idle();
      test_async_reset();
      go_idle();
      test_start_held();
      go_idle();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
